fsub_sweep_checker: RTL and testbench
=====================================

FSUB_SWEEP_CHECKER -- requirements
Module: fsub_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1, legal 1..15: clock cycles each test vector is held before the DUT response is sampled.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request one exhaustive sweep; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: terminate a running sweep.
REQ-006 SHALL have port dut_difference, input, 1: full-subtractor difference under test.
REQ-007 SHALL have port dut_borrow, input, 1: full-subtractor borrow under test.
REQ-008 SHALL have ports a, b, cin, output, 1 each: registered stimulus to the DUT.
REQ-009 SHALL have port busy, output, 1: high while in RUN.
REQ-010 SHALL have port done, output, 1: single-cycle pulse at sweep completion.
REQ-011 SHALL have port pass, output, 1: high when the completed sweep found zero mismatches.
REQ-012 SHALL have port err_count, output, 4: number of mismatching vectors, 0..8.
REQ-013 SHALL have port fail_vec, output, 8: bit i set when vector i ({a,b,cin}=i) mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1 at edge T SHALL enter RUN, clear err_count, fail_vec and pass, and drive {a,b,cin}=3'b000 from T+1.
REQ-016 Vector order SHALL be {a,b,cin}=0,1,...,7, with a as MSB.
REQ-017 Each vector SHALL be held exactly SETTLE cycles; DUT inputs SHALL be sampled at the last rising edge of the window, and the next vector driven from that same edge.
REQ-018 Expected values: difference = a^b^cin; borrow = (~a&b)|(~a&cin)|(b&cin).
REQ-019 A vector SHALL count as one mismatch if either output differs; err_count increments by 1 and fail_vec[i] is set at the sampling edge.
REQ-020 After vector 7 is sampled (edge T+8*SETTLE), the FSM SHALL enter DONE; done=1 and pass=(err_count==0 including vector 7) during cycle T+1+8*SETTLE; a,b,cin return to 0.
REQ-021 DONE SHALL last one cycle, then return to IDLE; start during DONE SHALL be ignored.
REQ-022 start during RUN SHALL be ignored, with no restart and no effect on counters.
REQ-023 abort=1 in RUN SHALL go to IDLE at the next edge: a,b,cin=0, busy=0, no done pulse, pass=0; partial err_count/fail_vec retained.
REQ-024 abort outside RUN SHALL have no effect; if abort and the vector-7 sample coincide, abort SHALL win.
REQ-025 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-026 err_count SHALL never exceed 8, and no wrap SHALL occur.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and a=b=cin=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, overriding start and abort.
REQ-028 rst asserted mid-RUN SHALL discard the sweep with no done pulse; the first start after rst deasserts SHALL begin at vector 0.

Verification
REQ-029 Correct full-subtractor model, SETTLE=1, start at T -> done at T+9, pass=1, err_count=0, fail_vec=8'h00.
REQ-030 DUT borrow stuck at 0 -> err_count=4, fail_vec=8'b1000_1110, pass=0.
REQ-031 DUT difference inverted, borrow correct -> err_count=8, fail_vec=8'hFF, pass=0.
REQ-032 SETTLE=3, correct model -> each vector held 3 cycles, done at T+25, pass=1.
REQ-033 start pulsed again during RUN, and abort during vector 4 on a second run -> first run is unaffected; on the second run busy falls the next cycle, there is no done pulse, pass=0, and a,b,cin=0.
REQ-034 rst during vector 5 -> all outputs reset next cycle; a new start gives a full clean sweep with pass=1.

Source files
------------

// File: rtl/fsub_sweep_checker.sv
// rtl/fsub_sweep_checker.sv - exhaustive full-subtractor sweep checker
// Drives all eight {a,b,cin} vectors, samples the DUT response and tallies mismatches.
module fsub_sweep_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_difference,
    input  logic       dut_borrow,
    output logic       a,
    output logic       b,
    output logic       cin,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_d;
    logic [7:0] fail_d;
    logic       pass_d, busy_d, done_d;

    logic       window_end;
    logic       exp_difference, exp_borrow, mismatch;

    assign a   = vec_q[2];
    assign b   = vec_q[1];
    assign cin = vec_q[0];

    assign window_end     = (cnt_q == LAST_CNT);
    assign exp_difference = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    assign exp_borrow     = (~vec_q[2] & vec_q[1]) | (~vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    assign mismatch       = (dut_difference != exp_difference) || (dut_borrow != exp_borrow);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= 3'd0;
            cnt_q     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_vec  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (abort)                             state_d = IDLE;
                else if (window_end && vec_q == 3'd7)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d  = 3'd0;
        cnt_d  = 4'd0;
        pass_d = pass;
        err_d  = err_count;
        fail_d = fail_vec;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d = 1'b0;
                    err_d  = 4'd0;
                    fail_d = 8'd0;
                end
            end
            RUN: begin
                // abort takes priority over the sample, including the final vector
                if (abort) begin
                    pass_d = 1'b0;
                end else if (window_end) begin
                    if (mismatch) begin
                        if (err_count != 4'd8) err_d = err_count + 4'd1;
                        fail_d[vec_q] = 1'b1;
                    end
                    if (vec_q == 3'd7) begin
                        pass_d = (err_count == 4'd0) && !mismatch;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end else begin
                    vec_d = vec_q;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_fsub_sweep_checker.sv
// tb/tb_fsub_sweep_checker.sv - randomized self-checking bench for fsub_sweep_checker
// Two instances (SETTLE=1 and SETTLE=3) each drive a faultable full-subtractor model.
module tb_fsub_sweep_checker;

    logic clk = 1'b0;
    logic rst;
    logic start_r [2];
    logic abort_r [2];
    logic a_o [2], b_o [2], c_o [2];
    logic busy_o [2], done_o [2], pass_o [2];
    logic [3:0] err_o [2];
    logic [7:0] fail_o [2];
    logic dd [2], db [2];

    logic [7:0] dmask, bmask;
    bit         bstuck;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    fsub_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_r[0]), .abort(abort_r[0]),
        .dut_difference(dd[0]), .dut_borrow(db[0]),
        .a(a_o[0]), .b(b_o[0]), .cin(c_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(err_o[0]), .fail_vec(fail_o[0])
    );

    fsub_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_r[1]), .abort(abort_r[1]),
        .dut_difference(dd[1]), .dut_borrow(db[1]),
        .a(a_o[1]), .b(b_o[1]), .cin(c_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(err_o[1]), .fail_vec(fail_o[1])
    );

    // reference subtraction: a - b - cin by plain arithmetic
    function automatic logic ref_d(input logic [2:0] i);
        int d;
        d = int'(i[2]) - int'(i[1]) - int'(i[0]);
        return (d % 2) != 0;
    endfunction

    function automatic logic ref_b(input logic [2:0] i);
        int d;
        d = int'(i[2]) - int'(i[1]) - int'(i[0]);
        return d < 0;
    endfunction

    function automatic logic model_d(input logic [2:0] i);
        return ref_d(i) ^ dmask[i];
    endfunction

    function automatic logic model_b(input logic [2:0] i);
        return bstuck ? 1'b0 : (ref_b(i) ^ bmask[i]);
    endfunction

    always_comb begin
        dd[0] = model_d({a_o[0], b_o[0], c_o[0]});
        db[0] = model_b({a_o[0], b_o[0], c_o[0]});
        dd[1] = model_d({a_o[1], b_o[1], c_o[1]});
        db[1] = model_b({a_o[1], b_o[1], c_o[1]});
    end

    function automatic logic [7:0] exp_fail();
        logic [7:0] f;
        f = 8'd0;
        for (int i = 0; i < 8; i++)
            f[i] = (model_d(3'(i)) != ref_d(3'(i))) || (model_b(3'(i)) != ref_b(3'(i)));
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input int k, input string tag);
        check({tag, "_abc"},  {a_o[k], b_o[k], c_o[k]}, 0);
        check({tag, "_busy"}, busy_o[k], 0);
        check({tag, "_done"}, done_o[k], 0);
        check({tag, "_pass"}, pass_o[k], 0);
        check({tag, "_err"},  err_o[k], 0);
        check({tag, "_fail"}, fail_o[k], 0);
    endtask

    // One sweep on instance k; restart_c: cycle to pulse start again; abort_v/rst_v: vector to interrupt at.
    task automatic run_sweep(input int k, input int restart_c, input int abort_v, input int rst_v);
        int s, v;
        logic [7:0] ef, part;
        s  = (k == 0) ? 1 : 3;
        ef = exp_fail();
        @(negedge clk);
        start_r[k] = 1'b1;
        for (int c = 1; c <= 8 * s + 2; c++) begin
            @(negedge clk);
            start_r[k] = 1'b0;
            if (c == restart_c) start_r[k] = 1'b1;
            v = (c - 1) / s;
            if (c <= 8 * s) begin
                check("run_abc", {a_o[k], b_o[k], c_o[k]}, v);
                check("run_busy", busy_o[k], 1);
                check("run_done", done_o[k], 0);
                if ((c - 1) % s == 0 && (v == abort_v || v == rst_v)) begin
                    part = ef & 8'((1 << v) - 1);
                    if (v == abort_v) abort_r[k] = 1'b1;
                    else              rst = 1'b1;
                    @(negedge clk);
                    if (v == abort_v) begin
                        abort_r[k] = 1'b0;
                        check("abort_abc",  {a_o[k], b_o[k], c_o[k]}, 0);
                        check("abort_busy", busy_o[k], 0);
                        check("abort_done", done_o[k], 0);
                        check("abort_pass", pass_o[k], 0);
                        check("abort_err",  err_o[k], $countones(part));
                        check("abort_fail", fail_o[k], part);
                        repeat (2 * s) begin
                            @(negedge clk);
                            check("abort_nodone", done_o[k], 0);
                        end
                    end else begin
                        rst = 1'b0;
                        check_idle_zero(k, "midrst");
                    end
                    return;
                end
            end else if (c == 8 * s + 1) begin
                check("done_pulse", done_o[k], 1);
                check("done_busy",  busy_o[k], 0);
                check("done_abc",   {a_o[k], b_o[k], c_o[k]}, 0);
                check("done_pass",  pass_o[k], (ef == 8'd0));
                check("done_err",   err_o[k], $countones(ef));
                check("done_fail",  fail_o[k], ef);
            end else begin
                check("post_done", done_o[k], 0);
                check("post_busy", busy_o[k], 0);
            end
        end
        start_r[k] = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_pass", pass_o[k], (ef == 8'd0));
        check("hold_err",  err_o[k], $countones(ef));
        check("hold_fail", fail_o[k], ef);
    endtask

    initial begin
        rst = 1'b1;
        dmask = 8'd0;
        bmask = 8'd0;
        bstuck = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_r[k] = 1'b0;
            abort_r[k] = 1'b0;
        end
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero(0, "reset0");
        check_idle_zero(1, "reset1");
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        rst = 1'b0;

        run_sweep(0, -1, -1, -1);
        run_sweep(1, -1, -1, -1);
        bstuck = 1'b1;
        run_sweep(0, -1, -1, -1);
        bstuck = 1'b0;
        dmask = 8'hFF;
        run_sweep(1, -1, -1, -1);
        dmask = 8'h00;

        run_sweep(0, 3, -1, -1);
        run_sweep(0, 9, -1, -1);
        run_sweep(1, 7, -1, -1);
        bmask = 8'h05;
        run_sweep(0, -1, 4, -1);
        run_sweep(1, -1, 4, -1);
        run_sweep(0, -1, 7, -1);
        bmask = 8'h00;

        @(negedge clk);
        abort_r[0] = 1'b1;
        @(negedge clk);
        abort_r[0] = 1'b0;
        check("idle_abort_busy", busy_o[0], 0);
        check("idle_abort_fail", fail_o[0], 8'h05);

        dmask = 8'h21;
        run_sweep(0, -1, -1, 5);
        run_sweep(1, -1, -1, 5);
        dmask = 8'h00;
        run_sweep(0, -1, -1, -1);

        for (int it = 0; it < 8; it++) begin
            dmask  = 8'($urandom);
            bmask  = 8'($urandom) & 8'($urandom);
            bstuck = ($urandom_range(0, 3) == 0);
            run_sweep(int'($urandom_range(0, 1)), -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
